trigger_conditioner: RTL and testbench

Conditions the four raw piezo comparator inputs before they reach the per-channel trigger timers. Each channel is synchronised, filtered so that only pulses of a minimum width qualify, and latched into a clean trigger level. Each channel is then locked out until an explicit rearm and a quiet period on the input. Every channel has the same fixed latency from input to trigger, so the time differences the timers measure between channels are preserved exactly.

---
 rtl/trigger_pkg.sv | 26 ++
 rtl/trigger_conditioner_if.sv | 36 +++
 rtl/trigger_channel.sv | 123 ++++++++++++
 rtl/trigger_conditioner.sv | 40 ++++
 tb/tb_trigger_conditioner.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/trigger_pkg.sv
// Shared definitions for the piezo trigger conditioner.
//   - trig_state_e : per-channel FSM state
//   - QCNT_W / HCNT_W : counter widths used while qualifying / holding off
//   - DEF_* : default parameter values for the conditioner and its channels
//   - is_armable() : true for states that count as "armed"
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    FIRED   = 2'd2,
    HOLDOFF = 2'd3
  } trig_state_e;

  localparam int QCNT_W = 8;
  localparam int HCNT_W = 16;

  localparam int DEF_CHANNELS       = 4;
  localparam int DEF_FILTER_LEN     = 4;
  localparam int DEF_HOLDOFF_CYCLES = 16;

  function automatic logic is_armable(trig_state_e s);
    return (s == IDLE) || (s == QUAL);
  endfunction

endpackage

// File: rtl/trigger_conditioner_if.sv
// Signal bundle between the comparator front end and the trigger timers.
//   raw_in    : asynchronous comparator outputs, one per channel
//   rearm     : one-cycle pulse releasing fired channels into holdoff
//   trigger   : conditioned trigger level per channel
//   armed     : every channel is in IDLE or QUAL
//   any_fired : OR of trigger
// master drives raw_in/rearm, slave (the conditioner) drives the rest.
interface trigger_conditioner_if
  import trigger_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS
);

  logic [CHANNELS-1:0] raw_in;
  logic                rearm;
  logic [CHANNELS-1:0] trigger;
  logic                armed;
  logic                any_fired;

  modport master (
    output raw_in,
    output rearm,
    input  trigger,
    input  armed,
    input  any_fired
  );

  modport slave (
    input  raw_in,
    input  rearm,
    output trigger,
    output armed,
    output any_fired
  );

endinterface

// File: rtl/trigger_channel.sv
// One trigger channel: 2-flop synchroniser, minimum-width pulse filter,
// latched trigger and rearm/holdoff lockout.
//   clk, reset : clock and synchronous active-high reset
//   raw_in     : asynchronous comparator output for this channel
//   rearm      : releases a FIRED channel into HOLDOFF
//   trigger    : registered, high exactly while the channel is FIRED
//   armable    : channel is in IDLE or QUAL
module trigger_channel
  import trigger_pkg::*;
#(
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic rearm,
  output logic trigger,
  output logic armable
);

  localparam logic [QCNT_W-1:0] QUAL_LAST = QCNT_W'(FILTER_LEN - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLDOFF_CYCLES - 1);

  logic              s1;
  logic              s2;
  logic              vld_p0;
  logic              vld_p1;
  logic              quiet;
  trig_state_e       state_q;
  trig_state_e       state_d;
  logic [HCNT_W-1:0] cnt_q;
  logic [HCNT_W-1:0] cnt_d;
  logic              trig_q;

  function automatic logic [HCNT_W-1:0] cnt_inc(logic [HCNT_W-1:0] c);
    return c + HCNT_W'(1);
  endfunction

  // Synchroniser stage; vld_p0/vld_p1 mark when s1/s2 hold a sample taken
  // after reset. Until then the holdoff treats the input as busy, so a pin
  // stuck high across reset is seen before the channel can ever reach IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      state_q <= HOLDOFF;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      s1      <= raw_in;
      s2      <= s1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= (state_d == FIRED);
    end
  end

  assign quiet = vld_p1 && !s2;

  // FSM / counter stage. One counter serves both the qualification count
  // (low QCNT_W bits) and the holdoff count (full width).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s2) begin
          if (FILTER_LEN == 1) begin
            state_d = FIRED;
            cnt_d   = '0;
          end else begin
            state_d = QUAL;
            cnt_d   = HCNT_W'(1);
          end
        end
      end
      QUAL: begin
        // rearm beats a qualification completing on the same edge
        if (rearm) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q[QCNT_W-1:0] == QUAL_LAST) begin
          state_d = FIRED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      FIRED: begin
        if (rearm) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end
      end
      HOLDOFF: begin
        if (!quiet) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      default: begin
        state_d = HOLDOFF;
        cnt_d   = '0;
      end
    endcase
  end

  assign trigger = trig_q;
  assign armable = is_armable(state_q);

endmodule

// File: rtl/trigger_conditioner.sv
// Conditions the raw piezo comparator inputs into clean, latched trigger
// levels. Every channel is an identical trigger_channel, so input-to-trigger
// latency is the same on all channels and inter-channel timing is preserved.
//   clk, reset : clock and synchronous active-high reset
//   bus        : trigger_conditioner_if slave (raw_in, rearm in;
//                trigger, armed, any_fired out)
module trigger_conditioner
  import trigger_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  trigger_conditioner_if.slave  bus
);

  logic [CHANNELS-1:0] trig_w;
  logic [CHANNELS-1:0] arm_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    trigger_channel #(
      .FILTER_LEN     (FILTER_LEN),
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .raw_in  (bus.raw_in[i]),
      .rearm   (bus.rearm),
      .trigger (trig_w[i]),
      .armable (arm_w[i])
    );
  end

  assign bus.trigger   = trig_w;
  assign bus.armed     = &arm_w;
  assign bus.any_fired = |trig_w;

endmodule

// File: tb/tb_trigger_conditioner.sv
module tb_trigger_conditioner;

  localparam int CH = 4;

  logic clk;
  logic reset;

  trigger_conditioner_if #(.CHANNELS(CH)) bus ();

  trigger_conditioner #(
    .CHANNELS       (CH),
    .FILTER_LEN     (4),
    .HOLDOFF_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  raw;
    logic        rearm;
    logic [3:0]  trig;
    logic        armed;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(string tag, logic [3:0] raw, logic rearm,
                              logic [3:0] trig, logic armed, int n = 1);
    for (int k = 0; k < n; k++) tbl.push_back('{tag, raw, rearm, trig, armed});
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_outputs(string name, logic [3:0] trig, logic armed);
    chk({name, " trigger"}, bus.trigger, trig);
    chk({name, " armed"}, {3'b000, bus.armed}, {3'b000, armed});
    chk({name, " any_fired"}, {3'b000, bus.any_fired}, {3'b000, |trig});
  endtask

  // Each row: inputs applied before an edge, outputs expected after it.
  task automatic run_tbl();
    foreach (tbl[i]) begin
      bus.raw_in = tbl[i].raw;
      bus.rearm  = tbl[i].rearm;
      @(posedge clk); #1;
      chk_outputs($sformatf("%s[%0d]", tbl[i].tag, i), tbl[i].trig, tbl[i].armed);
    end
    tbl.delete();
    bus.rearm = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bus.raw_in = 4'b0000;
    bus.rearm  = 1'b0;

    // 1: reset with inputs low, armed rises 10 edges after release
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk_outputs($sformatf("in_reset[%0d]", k), 4'b0000, 1'b0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk_outputs($sformatf("post_reset[%0d]", k), 4'b0000, (k >= 10));
    end

    // 2: channels 0 and 2 rise before the same edge E, fire after E+5
    add("lat_wait", 4'b0101, 0, 4'b0000, 1, 5);
    add("lat_fire", 4'b0101, 0, 4'b0101, 0);
    add("lat_rearm", 4'b0000, 1, 4'b0000, 0);
    add("lat_hold", 4'b0000, 0, 4'b0000, 0, 8);
    add("lat_idle", 4'b0000, 0, 4'b0000, 1);
    run_tbl();

    // 3: 3-cycle glitch rejected, 4-cycle pulse fires
    add("glitch3", 4'b0010, 0, 4'b0000, 1, 3);
    add("glitch_lo", 4'b0000, 0, 4'b0000, 1, 4);
    add("pulse4", 4'b0010, 0, 4'b0000, 1, 4);
    add("pulse4_lo", 4'b0000, 0, 4'b0000, 1);
    add("pulse4_fire", 4'b0000, 0, 4'b0010, 0, 2);
    add("p4_rearm", 4'b0000, 1, 4'b0000, 0);
    add("p4_hold", 4'b0000, 0, 4'b0000, 0, 7);
    add("p4_idle", 4'b0000, 0, 4'b0000, 1);
    run_tbl();

    // 4: latch, rearm, holdoff restarted by a high sample (rearm ignored)
    add("ch3_pulse", 4'b1000, 0, 4'b0000, 1, 4);
    add("ch3_lo", 4'b0000, 0, 4'b0000, 1);
    add("ch3_fire", 4'b0000, 0, 4'b1000, 0);
    add("ch3_latch", 4'b0000, 0, 4'b1000, 0, 3);
    add("ch3_rearm", 4'b0000, 1, 4'b0000, 0);
    add("ch3_hold_a", 4'b0000, 0, 4'b0000, 0);
    add("ch3_hold_rearm", 4'b0000, 1, 4'b0000, 0);
    add("ch3_hold_b", 4'b0000, 0, 4'b0000, 0);
    add("ch3_hold_hi", 4'b1000, 0, 4'b0000, 0);
    add("ch3_hold_c", 4'b0000, 0, 4'b0000, 0, 9);
    add("ch3_idle", 4'b0000, 0, 4'b0000, 1);
    run_tbl();

    // 5: rearm on the qualifying edge of channel 0 wins
    add("coin_pulse", 4'b0001, 0, 4'b0000, 1, 4);
    add("coin_lo", 4'b0000, 0, 4'b0000, 1);
    add("coin_rearm", 4'b0000, 1, 4'b0000, 1);
    add("coin_after", 4'b0000, 0, 4'b0000, 1, 3);
    add("fresh_pulse", 4'b0001, 0, 4'b0000, 1, 4);
    add("fresh_lo", 4'b0000, 0, 4'b0000, 1);
    add("fresh_fire", 4'b0000, 0, 4'b0001, 0);
    run_tbl();

    // 6: reset while channel 0 is fired, with raw_in[2] stuck high through it
    bus.raw_in = 4'b0100;
    reset      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_outputs($sformatf("stuck_reset[%0d]", k), 4'b0000, 1'b0);
    end
    reset = 1'b0;
    add("stuck_hi", 4'b0100, 0, 4'b0000, 0, 20);
    add("stuck_lo", 4'b0000, 0, 4'b0000, 0, 9);
    add("stuck_idle", 4'b0000, 0, 4'b0000, 1);
    add("stuck_pulse", 4'b0100, 0, 4'b0000, 1, 4);
    add("stuck_pulse_lo", 4'b0000, 0, 4'b0000, 1);
    add("stuck_fire", 4'b0000, 0, 4'b0100, 0);
    run_tbl();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
